// File: rtl/delta_backprop.sv
// Backpropagation error vector: delta_out[j] = relu'(z[j]) * sat((sum_i w[i][j]*delta_in[i]) >>> FW),
// computed with one shared multiplier over NEURON_NUM^2 MAC cycles per start.
module delta_backprop #(
    parameter int NEURON_NUM          = 5,
    parameter int NEURON_OUTPUT_WIDTH = 10,
    parameter int DELTA_CELL_WIDTH    = 10,
    parameter int WEIGHT_CELL_WIDTH   = 16,
    parameter int FRACTION_WIDTH      = 0
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 start,
    input  logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]   w,
    input  logic [NEURON_NUM*DELTA_CELL_WIDTH-1:0]               delta_in,
    input  logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]            z,
    output logic [NEURON_NUM*DELTA_CELL_WIDTH-1:0]               delta_out,
    output logic                                                 valid,
    output logic                                                 busy
);
    localparam int N   = NEURON_NUM;
    localparam int NOW = NEURON_OUTPUT_WIDTH;
    localparam int DW  = DELTA_CELL_WIDTH;
    localparam int WCW = WEIGHT_CELL_WIDTH;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int PW  = WCW + DW;
    localparam int AW  = WCW + DW + CW;

    localparam int                    SAT_MAX_I = (1 << (DW - 1)) - 1;
    localparam logic signed [AW-1:0] SAT_MAX   = AW'(SAT_MAX_I);
    localparam logic signed [AW-1:0] SAT_MIN   = AW'(-SAT_MAX_I - 1);

    typedef enum logic {ST_IDLE, ST_MAC} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          i_q, j_q;
    logic signed [AW-1:0]   acc_q;
    logic signed [WCW-1:0]  w_q [N][N];
    logic signed [DW-1:0]   d_q [N];
    logic signed [NOW-1:0]  z_q [N];
    logic signed [DW-1:0]   res_q [N];
    logic [N*DW-1:0]        delta_out_q;
    logic                   valid_q;

    logic                   accept, last_row, last_col;
    logic signed [PW-1:0]   w_ext, d_ext, prod;
    logic signed [AW-1:0]   acc_sum, shifted;
    logic signed [DW-1:0]   sat_val, col_res;
    logic                   relu_d;

    assign accept   = (state_q == ST_IDLE) && start;
    assign last_row = (i_q == CW'(N - 1));
    assign last_col = (j_q == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: default assignment first so every path drives state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)                state_d = ST_MAC;
            ST_MAC:  if (last_row && last_col) state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_MAC);
        valid     = valid_q;
        delta_out = delta_out_q;
    end

    // NOTE: operand snapshots carry no reset; they are always reloaded on accept before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int ii = 0; ii < N; ii++) begin
                for (int jj = 0; jj < N; jj++)
                    w_q[ii][jj] <= w[(ii*N+jj)*WCW +: WCW];
                d_q[ii] <= delta_in[ii*DW +: DW];
                z_q[ii] <= z[ii*NOW +: NOW];
            end
        end
    end

    always_comb begin
        w_ext   = PW'(w_q[i_q][j_q]);
        d_ext   = PW'(d_q[i_q]);
        prod    = w_ext * d_ext;
        acc_sum = acc_q + AW'(prod);
        shifted = acc_sum >>> FRACTION_WIDTH;
        if (shifted > SAT_MAX)      sat_val = DW'(SAT_MAX);
        else if (shifted < SAT_MIN) sat_val = DW'(SAT_MIN);
        else                        sat_val = DW'(shifted);
        relu_d  = !z_q[j_q][NOW-1] && (z_q[j_q] != '0);
        col_res = relu_d ? sat_val : '0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_q         <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            valid_q     <= 1'b0;
            delta_out_q <= '0;
            for (int k = 0; k < N; k++) res_q[k] <= '0;
        end else begin
            valid_q <= 1'b0;
            if (accept) begin
                i_q   <= '0;
                j_q   <= '0;
                acc_q <= '0;
            end else if (state_q == ST_MAC) begin
                if (last_row) begin
                    res_q[j_q] <= col_res;
                    acc_q      <= '0;
                    i_q        <= '0;
                    j_q        <= j_q + CW'(1);
                    if (last_col) begin
                        // Final column bypasses res_q so its value lands on the same edge.
                        j_q     <= '0;
                        valid_q <= 1'b1;
                        for (int k = 0; k < N; k++)
                            delta_out_q[k*DW +: DW] <= (k == N - 1) ? col_res : res_q[k];
                    end
                end else begin
                    acc_q <= acc_sum;
                    i_q   <= i_q + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_delta_backprop.sv
// Self-checking bench for delta_backprop: directed scenarios plus random vectors against
// a plain-arithmetic reference, on two instances (FRACTION_WIDTH 0 and 4) sharing inputs.
module tb_delta_backprop;
    localparam int N   = 5;
    localparam int NOW = 10;
    localparam int DW  = 10;
    localparam int WCW = 16;

    logic                 clk = 1'b0;
    logic                 rst, start;
    logic [N*N*WCW-1:0]   w;
    logic [N*DW-1:0]      delta_in;
    logic [N*NOW-1:0]     z;
    logic [N*DW-1:0]      do0, do1;
    logic                 v0, v1, b0, b1;

    int checks = 0;
    int errors = 0;
    int wm [N*N];
    int dm [N];
    int zm [N];

    always #5 clk = ~clk;

    delta_backprop #(.FRACTION_WIDTH(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .w(w), .delta_in(delta_in), .z(z),
        .delta_out(do0), .valid(v0), .busy(b0));

    delta_backprop #(.FRACTION_WIDTH(4)) dut1 (
        .clk(clk), .rst(rst), .start(start), .w(w), .delta_in(delta_in), .z(z),
        .delta_out(do1), .valid(v1), .busy(b1));

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*DW-1:0] model(input int fw);
        logic [N*DW-1:0] r;
        longint s;
        r = '0;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int i = 0; i < N; i++) s += longint'(wm[i*N+j]) * longint'(dm[i]);
            s = s >>> fw;
            if (s > 511)  s = 511;
            if (s < -512) s = -512;
            if (zm[j] <= 0) s = 0;
            r[j*DW +: DW] = DW'(s);
        end
        return r;
    endfunction

    task automatic apply;
        for (int k = 0; k < N*N; k++) w[k*WCW +: WCW] = WCW'(wm[k]);
        for (int k = 0; k < N; k++) begin
            delta_in[k*DW +: DW] = DW'(dm[k]);
            z[k*NOW +: NOW]      = NOW'(zm[k]);
        end
    endtask

    task automatic launch;
        apply();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (v0 !== 1'b1 && lat < 60) begin
            cyc();
            lat++;
        end
    endtask

    task automatic fill(input int wdiag, input int woff, input int dval, input int zval);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) wm[i*N+j] = (i == j) ? wdiag : woff;
        for (int k = 0; k < N; k++) begin
            dm[k] = dval;
            zm[k] = zval;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1;
        fill(1, 0, 1, 1);
        apply();
        cyc(); cyc();
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", b0); end
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", v0); end
        checks++; if (do0 !== '0)  begin errors++; $display("FAIL reset_delta_out got %h want 0", do0); end
        checks++; if (do1 !== '0)  begin errors++; $display("FAIL reset_delta_out_fw4 got %h want 0", do1); end
        rst = 1'b0; start = 1'b0;
        cyc();
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL reset_start_priority busy got %b want 0", b0); end
    endtask

    task automatic test_identity;
        logic [N*DW-1:0] e0;
        int lat;
        fill(1, 0, 0, 100);
        for (int k = 0; k < N; k++) dm[k] = 5 - k;
        e0 = model(0);
        launch();
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL identity_busy_after_accept got %b want 1", b0); end
        wait_valid(lat);
        checks++; if (lat != 25) begin errors++; $display("FAIL identity_latency got %0d want 25", lat); end
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL identity_busy_on_valid got %b want 0", b0); end
        checks++; if (do0 !== e0)  begin errors++; $display("FAIL identity_result got %h want %h", do0, e0); end
        checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL identity_valid_fw4 got %b want 1", v1); end
        cyc();
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL identity_valid_pulse got %b want 0", v0); end
        checks++; if (do0 !== e0)  begin errors++; $display("FAIL identity_hold got %h want %h", do0, e0); end
    endtask

    task automatic test_relu_mask;
        logic [N*DW-1:0] e0;
        int lat;
        fill(1, 0, 0, 100);
        for (int k = 0; k < N; k++) dm[k] = 5 - k;
        zm[2] = 0; zm[4] = -3;
        e0 = model(0);
        launch();
        wait_valid(lat);
        checks++; if (lat != 25)  begin errors++; $display("FAIL relu_latency got %0d want 25", lat); end
        checks++; if (do0 !== e0) begin errors++; $display("FAIL relu_result got %h want %h", do0, e0); end
    endtask

    task automatic test_saturation;
        logic [N*DW-1:0] e0;
        int lat;
        for (int c = 0; c < 3; c++) begin
            case (c)
                0: fill(1000, 1000, 500, 7);
                1: fill(-1, -1, 1, 7);
                default: fill(-1000, -1000, 500, 7);
            endcase
            e0 = model(0);
            launch();
            wait_valid(lat);
            checks++; if (do0 !== e0) begin errors++; $display("FAIL saturation_case%0d got %h want %h", c, do0, e0); end
        end
    endtask

    task automatic test_fraction;
        logic [N*DW-1:0] e1;
        int lat;
        fill(16, 0, 0, 50);
        dm[0] = 7; dm[1] = -7; dm[2] = 3; dm[3] = 0; dm[4] = 1;
        e1 = model(4);
        launch();
        wait_valid(lat);
        checks++; if (do1 !== e1) begin errors++; $display("FAIL fraction_diag got %h want %h", do1, e1); end
        fill(16, 8, 2, 50);
        e1 = model(4);
        launch();
        wait_valid(lat);
        checks++; if (do1 !== e1) begin errors++; $display("FAIL fraction_offdiag got %h want %h", do1, e1); end
    endtask

    task automatic randomize_inputs;
        for (int k = 0; k < N*N; k++) wm[k] = int'($urandom_range(0, 65535)) - 32768;
        for (int k = 0; k < N; k++) begin
            dm[k] = int'($urandom_range(0, 1023)) - 512;
            zm[k] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 1023)) - 512;
        end
    endtask

    task automatic test_random;
        logic [N*DW-1:0] e0, e1;
        int lat;
        for (int r = 0; r < 10; r++) begin
            randomize_inputs();
            if (r % 3 == 0)
                for (int k = 0; k < N*N; k++) wm[k] = wm[k] % 64;
            e0 = model(0);
            e1 = model(4);
            launch();
            wait_valid(lat);
            checks++; if (lat != 25)  begin errors++; $display("FAIL random%0d_latency got %0d want 25", r, lat); end
            checks++; if (do0 !== e0) begin errors++; $display("FAIL random%0d_fw0 got %h want %h", r, do0, e0); end
            checks++; if (do1 !== e1) begin errors++; $display("FAIL random%0d_fw4 got %h want %h", r, do1, e1); end
        end
    endtask

    task automatic test_ignore_start;
        logic [N*DW-1:0] e0;
        int lat, extra;
        randomize_inputs();
        e0 = model(0);
        launch();
        for (int c = 0; c < 9; c++) cyc();
        randomize_inputs();
        apply();
        start = 1'b1;
        cyc();
        start = 1'b0;
        randomize_inputs();
        apply();
        lat = 10;
        while (v0 !== 1'b1 && lat < 60) begin
            cyc();
            lat++;
        end
        checks++; if (lat != 25)  begin errors++; $display("FAIL ignore_latency got %0d want 25", lat); end
        checks++; if (do0 !== e0) begin errors++; $display("FAIL ignore_result got %h want %h", do0, e0); end
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (v0 === 1'b1 || b0 === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL ignore_no_second_run got %0d want 0", extra); end
    endtask

    task automatic test_back_to_back;
        logic [N*DW-1:0] e0;
        int lat;
        randomize_inputs();
        launch();
        wait_valid(lat);
        randomize_inputs();
        e0 = model(0);
        launch();
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL b2b_accept busy got %b want 1", b0); end
        wait_valid(lat);
        checks++; if (lat != 25)  begin errors++; $display("FAIL b2b_latency got %0d want 25", lat); end
        checks++; if (do0 !== e0) begin errors++; $display("FAIL b2b_result got %h want %h", do0, e0); end
    endtask

    task automatic test_reset_mid;
        logic [N*DW-1:0] e0;
        int lat, extra;
        randomize_inputs();
        launch();
        for (int c = 0; c < 12; c++) cyc();
        rst = 1'b1;
        cyc();
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", b0); end
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", v0); end
        checks++; if (do0 !== '0)  begin errors++; $display("FAIL midrst_delta_out got %h want 0", do0); end
        rst = 1'b0;
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (v0 === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL midrst_no_valid got %0d want 0", extra); end
        randomize_inputs();
        e0 = model(0);
        launch();
        wait_valid(lat);
        checks++; if (lat != 25)  begin errors++; $display("FAIL midrst_rerun_latency got %0d want 25", lat); end
        checks++; if (do0 !== e0) begin errors++; $display("FAIL midrst_rerun_result got %h want %h", do0, e0); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; w = '0; delta_in = '0; z = '0;
        test_reset();
        test_identity();
        test_relu_mask();
        test_saturation();
        test_fraction();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
